// File: rtl/timer_sfr_ctrl.sv
// SFR/control stage in front of the two timer cores: holds TMOD/TCON/THx/TLx,
// makes the machine-cycle tick, synchronises pins and turns core overflow into TF flags.
module timer_sfr_ctrl #(
  parameter int PRESCALE = 12,
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_wr,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       int0_n,
  input  logic       int1_n,
  output logic       t0_ts,
  output logic [2:0] t0_mode,
  output logic [7:0] t0_th,
  output logic [7:0] t0_tl,
  output logic       t0_cnt,
  input  logic [7:0] t0_th_nxt,
  input  logic [7:0] t0_tl_nxt,
  input  logic       t0_ovf,
  output logic       t1_ts,
  output logic [2:0] t1_mode,
  output logic [7:0] t1_th,
  output logic [7:0] t1_tl,
  output logic       t1_cnt,
  input  logic [7:0] t1_th_nxt,
  input  logic [7:0] t1_tl_nxt,
  input  logic       t1_ovf,
  input  logic       irq_ack0,
  input  logic       irq_ack1,
  output logic       tf0,
  output logic       tf1
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TL1  = 8'h8B;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] ADDR_TH1  = 8'h8D;

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [SYNC_STG-1:0] t0_sync, t1_sync, int0_sync, int1_sync;
  logic [7:0]          tmod, tcon, th0, tl0, th1, tl1;
  logic [7:0]          tcon_nxt;
  logic                ovf_d0, ovf_d1;
  logic                run0, run1;
  logic                tf0_set, tf1_set;
  logic                wr_tcon, wr_tmod, wr_tl0, wr_tl1, wr_th0, wr_th1;

  // Free-running prescaler; never gated by TR so tick phase is independent of software.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t0_sync   <= '0;
      t1_sync   <= '0;
      int0_sync <= '0;
      int1_sync <= '0;
    end else begin
      t0_sync   <= {t0_sync[SYNC_STG-2:0], t0_pin};
      t1_sync   <= {t1_sync[SYNC_STG-2:0], t1_pin};
      int0_sync <= {int0_sync[SYNC_STG-2:0], int0_n};
      int1_sync <= {int1_sync[SYNC_STG-2:0], int1_n};
    end
  end

  assign t0_cnt = t0_sync[SYNC_STG-1];
  assign t1_cnt = t1_sync[SYNC_STG-1];

  assign wr_tcon = sfr_wr && (sfr_addr == ADDR_TCON);
  assign wr_tmod = sfr_wr && (sfr_addr == ADDR_TMOD);
  assign wr_tl0  = sfr_wr && (sfr_addr == ADDR_TL0);
  assign wr_tl1  = sfr_wr && (sfr_addr == ADDR_TL1);
  assign wr_th0  = sfr_wr && (sfr_addr == ADDR_TH0);
  assign wr_th1  = sfr_wr && (sfr_addr == ADDR_TH1);

  assign run0 = tcon[4] & (~tmod[3] | int0_sync[SYNC_STG-1]);
  assign run1 = tcon[6] & (~tmod[7] | int1_sync[SYNC_STG-1]);

  // Counter mode enables the core every clk; the core itself looks for the falling edge.
  assign t0_ts = tmod[2] ? run0 : (run0 & tick);
  assign t1_ts = tmod[6] ? run1 : (run1 & tick);

  assign t0_mode = tmod[2:0];
  assign t1_mode = tmod[6:4];
  assign t0_th   = th0;
  assign t0_tl   = tl0;
  assign t1_th   = th1;
  assign t1_tl   = tl1;
  assign tf0     = tcon[5];
  assign tf1     = tcon[7];

  assign tf0_set = t0_ovf & ~ovf_d0 & tcon[4];
  assign tf1_set = t1_ovf & ~ovf_d1 & tcon[6];

  // TF priority: hardware set over acknowledge over software write.
  always_comb begin
    tcon_nxt = tcon;
    if (wr_tcon)  tcon_nxt = sfr_wdata;
    if (irq_ack0) tcon_nxt[5] = 1'b0;
    if (irq_ack1) tcon_nxt[7] = 1'b0;
    if (tf0_set)  tcon_nxt[5] = 1'b1;
    if (tf1_set)  tcon_nxt[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmod   <= '0;
      tcon   <= '0;
      th0    <= '0;
      tl0    <= '0;
      th1    <= '0;
      tl1    <= '0;
      ovf_d0 <= 1'b0;
      ovf_d1 <= 1'b0;
    end else begin
      tmod   <= wr_tmod ? sfr_wdata : tmod;
      tcon   <= tcon_nxt;
      th0    <= wr_th0 ? sfr_wdata : t0_th_nxt;
      tl0    <= wr_tl0 ? sfr_wdata : t0_tl_nxt;
      th1    <= wr_th1 ? sfr_wdata : t1_th_nxt;
      tl1    <= wr_tl1 ? sfr_wdata : t1_tl_nxt;
      ovf_d0 <= t0_ovf;
      ovf_d1 <= t1_ovf;
    end
  end

  always_comb begin
    sfr_rdata = 8'h00;
    sfr_hit   = 1'b1;
    case (sfr_addr)
      ADDR_TCON: sfr_rdata = tcon;
      ADDR_TMOD: sfr_rdata = tmod;
      ADDR_TL0:  sfr_rdata = tl0;
      ADDR_TL1:  sfr_rdata = tl1;
      ADDR_TH0:  sfr_rdata = th0;
      ADDR_TH1:  sfr_rdata = th1;
      default:   sfr_hit   = 1'b0;
    endcase
  end

endmodule
